// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage_pkg
// Brief    : Shared encodings for the ALU result stage: source selects,
//            status-flag bit positions and the flag reset value.
// Revision : 1.0 - initial release
// ============================================================================
package alu_result_stage_pkg;

    typedef enum logic [1:0] {
        OSEL_ADD   = 2'b00,
        OSEL_SHIFT = 2'b01,
        OSEL_LOGIC = 2'b10,
        OSEL_PASS  = 2'b11
    } osel_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Z set, everything else clear: the flags of a zero result.
    localparam logic [3:0] FLAG_RESET = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage_if
// Brief    : Function-unit results, handshake and status outputs of the ALU
//            result stage. master = producer/consumer side, slave = stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       osel;
    logic [3:0]       flag_we;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] logic_y;
    logic [WIDTH-1:0] pass_y;
    logic             add_c;
    logic             add_v;
    logic             shift_c;
    logic             shift_v;
    logic             logic_c;
    logic             logic_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             n;
    logic             v;
    logic             z;
    logic             clr_sticky;
    logic             sticky_v;

    modport master (
        output in_valid, osel, flag_we, add_y, shift_y, logic_y, pass_y,
               add_c, add_v, shift_c, shift_v, logic_c, logic_v,
               out_ready, clr_sticky,
        input  in_ready, out_valid, y, c, n, v, z, sticky_v
    );

    modport slave (
        input  in_valid, osel, flag_we, add_y, shift_y, logic_y, pass_y,
               add_c, add_v, shift_c, shift_v, logic_c, logic_v,
               out_ready, clr_sticky,
        output in_ready, out_valid, y, c, n, v, z, sticky_v
    );

endinterface
`default_nettype wire

// File: rtl/alu_flag_reg.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_reg
// Brief    : C/N/V/Z status register with per-bit write enable and optional
//            sticky overflow (enabled by ALU_STICKY_OVF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_reg
    import alu_result_stage_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       load,
    input  wire logic [3:0] flag_we,
    input  wire logic [3:0] flag_in,
    input  wire logic       is_pass,
    input  wire logic       clr_sticky,
    output logic      [3:0] flags,
    output logic            sticky_v
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (load) begin
            flags_d = (flags_q & ~flag_we) | (flag_in & flag_we);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= FLAG_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;
    logic sticky_d;

    // Set is evaluated after clear so a same-cycle set wins; PASS only
    // re-presents the current V and must never count as a new overflow.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (load && flag_we[FLAG_V] && flag_in[FLAG_V] && !is_pass) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_sticky_inputs;
    assign unused_sticky_inputs = &{1'b0, clr_sticky, is_pass};
    assign sticky_v             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : Selects an ALU unit result, derives N/Z and captures result and
//            flags into a one-entry valid/ready stage. Optional sticky
//            overflow via ALU_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_result_stage_if.slave  bus
);

    logic [WIDTH-1:0] sel_y;
    logic             sel_c;
    logic             sel_v;
    logic             is_pass;
    logic [3:0]       sel_flags;
    logic [3:0]       flags;
    logic             accept;

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             out_valid_q;
    logic             out_valid_d;

    // PASS re-presents the current C/V so those bits never change under it.
    always_comb begin
        sel_y   = bus.add_y;
        sel_c   = bus.add_c;
        sel_v   = bus.add_v;
        is_pass = 1'b0;
        case (osel_e'(bus.osel))
            OSEL_ADD: begin
                sel_y = bus.add_y;
                sel_c = bus.add_c;
                sel_v = bus.add_v;
            end
            OSEL_SHIFT: begin
                sel_y = bus.shift_y;
                sel_c = bus.shift_c;
                sel_v = bus.shift_v;
            end
            OSEL_LOGIC: begin
                sel_y = bus.logic_y;
                sel_c = bus.logic_c;
                sel_v = bus.logic_v;
            end
            OSEL_PASS: begin
                sel_y   = bus.pass_y;
                sel_c   = flags[FLAG_C];
                sel_v   = flags[FLAG_V];
                is_pass = 1'b1;
            end
            default: begin
                sel_y = bus.add_y;
            end
        endcase
    end

    always_comb begin
        sel_flags         = 4'b0000;
        sel_flags[FLAG_C] = sel_c;
        sel_flags[FLAG_N] = sel_y[WIDTH-1];
        sel_flags[FLAG_V] = sel_v;
        sel_flags[FLAG_Z] = (sel_y == '0);
    end

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            y_d         = sel_y;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    alu_flag_reg u_flag_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .flag_we    (bus.flag_we),
        .flag_in    (sel_flags),
        .is_pass    (is_pass),
        .clr_sticky (bus.clr_sticky),
        .flags      (flags),
        .sticky_v   (bus.sticky_v)
    );

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = flags[FLAG_C];
    assign bus.n         = flags[FLAG_N];
    assign bus.v         = flags[FLAG_V];
    assign bus.z         = flags[FLAG_Z];

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Brief    : Directed bench for alu_result_stage with reference model,
//            scoreboard queue and drain-side monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    localparam int WIDTH = 8;
`ifdef ALU_STICKY_OVF_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [3:0]       flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.c, bus.n, bus.v, bus.z};
    endfunction

    // Reference model: tracks occupancy, flags and sticky; pushes one entry per accept.
    bit               m_ov     = 1'b0;
    logic [3:0]       m_flags  = FLAG_RESET;
    bit               m_sticky = 1'b0;
    logic [WIDTH-1:0] m_y;
    logic             m_c;
    logic             m_v;
    logic [3:0]       m_nf;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ov     = 1'b0;
            m_flags  = FLAG_RESET;
            m_sticky = 1'b0;
            sb_q.delete();
        end else if (bus.in_valid && (!m_ov || bus.out_ready)) begin
            case (bus.osel)
                2'b00:   begin m_y = bus.add_y;   m_c = bus.add_c;   m_v = bus.add_v;   end
                2'b01:   begin m_y = bus.shift_y; m_c = bus.shift_c; m_v = bus.shift_v; end
                2'b10:   begin m_y = bus.logic_y; m_c = bus.logic_c; m_v = bus.logic_v; end
                default: begin m_y = bus.pass_y;  m_c = m_flags[3];  m_v = m_flags[1];  end
            endcase
            m_nf    = {m_c, m_y[WIDTH-1], m_v, (m_y == 0)};
            m_flags = (m_flags & ~bus.flag_we) | (m_nf & bus.flag_we);
            if (STICKY_EN) begin
                if (bus.clr_sticky) m_sticky = 1'b0;
                if (bus.flag_we[1] && m_v && bus.osel != 2'b11) m_sticky = 1'b1;
            end
            sb_q.push_back('{y: m_y, flags: m_flags});
            m_ov = 1'b1;
        end else begin
            if (bus.out_ready) m_ov = 1'b0;
            if (STICKY_EN && bus.clr_sticky) m_sticky = 1'b0;
        end
    end

    // Monitor: compares handshake/status every cycle and pops on each drain.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
            check("flags", 32'(dut_flags()), 32'(m_flags));
            check("sticky_v", 32'(bus.sticky_v), 32'(m_sticky));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL drain: result presented with empty scoreboard at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("drain_y", 32'(bus.y), 32'(e.y));
                    check("drain_flags", 32'(dut_flags()), 32'(e.flags));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] osel, input logic [3:0] we,
                         input logic [WIDTH-1:0] yv, input logic cv, input logic vv);
        bus.in_valid = 1'b1;
        bus.osel     = osel;
        bus.flag_we  = we;
        case (osel)
            2'b00:   begin bus.add_y = yv;   bus.add_c = cv;   bus.add_v = vv;   end
            2'b01:   begin bus.shift_y = yv; bus.shift_c = cv; bus.shift_v = vv; end
            2'b10:   begin bus.logic_y = yv; bus.logic_c = cv; bus.logic_v = vv; end
            default: begin bus.pass_y = yv; end
        endcase
    endtask

    initial begin
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        bus.osel       = 2'b00;
        bus.flag_we    = 4'b0000;
        bus.add_y      = '0;
        bus.shift_y    = '0;
        bus.logic_y    = '0;
        bus.pass_y     = '0;
        bus.add_c      = 1'b0;
        bus.add_v      = 1'b0;
        bus.shift_c    = 1'b0;
        bus.shift_v    = 1'b0;
        bus.logic_c    = 1'b0;
        bus.logic_v    = 1'b0;
        bus.clr_sticky = 1'b0;
        rst_n          = 1'b0;

        // Reset held two cycles with an operation offered
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_y", 32'(bus.y), 32'h00);
        check("rst_flags", 32'(dut_flags()), 32'b0001);
        check("rst_sticky", 32'(bus.sticky_v), 32'h0);

        // ADD with every flag written
        rst_n = 1'b1;
        drive(2'b00, 4'b1111, 8'h80, 1'b1, 1'b1);
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("add_y", 32'(bus.y), 32'h80);
        check("add_flags", 32'(dut_flags()), 32'b1110);
        check("add_out_valid", 32'(bus.out_valid), 32'h1);

        // LOGIC with only Z written; drain and accept in the same edge
        bus.out_ready = 1'b1;
        drive(2'b10, 4'b0001, 8'h00, 1'b0, 1'b0);
        step();
        check("logic_y", 32'(bus.y), 32'h00);
        check("logic_flags", 32'(dut_flags()), 32'b1111);
        check("logic_out_valid", 32'(bus.out_valid), 32'h1);

        // Backpressure: SHIFT offered while the consumer stalls
        bus.out_ready = 1'b0;
        drive(2'b01, 4'b1111, 8'h3C, 1'b0, 1'b0);
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("bp_y_hold1", 32'(bus.y), 32'h00);
        check("bp_flags_hold", 32'(dut_flags()), 32'b1111);
        step();
        check("bp_y_hold2", 32'(bus.y), 32'h00);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("shift_y", 32'(bus.y), 32'h3C);
        check("shift_flags", 32'(dut_flags()), 32'b0000);

        // PASS keeps C/V: first establish C=1, V=0
        drive(2'b00, 4'b1111, 8'h01, 1'b1, 1'b0);
        step();
        check("pre_pass_flags", 32'(dut_flags()), 32'b1000);
        drive(2'b11, 4'b1111, 8'h5A, 1'b0, 1'b0);
        step();
        check("pass_y", 32'(bus.y), 32'h5A);
        check("pass_flags", 32'(dut_flags()), 32'b1000);

        // Sticky overflow sequence
        drive(2'b00, 4'b0010, 8'h7F, 1'b0, 1'b1);
        step();
        check("sticky_set", 32'(bus.sticky_v), 32'(STICKY_EN));
        check("sticky_set_flags", 32'(dut_flags()), 32'b1010);
        drive(2'b00, 4'b1111, 8'h10, 1'b0, 1'b0);
        step();
        check("sticky_hold", 32'(bus.sticky_v), 32'(STICKY_EN));
        bus.clr_sticky = 1'b1;
        drive(2'b00, 4'b0010, 8'h80, 1'b0, 1'b1);
        step();
        check("sticky_set_wins", 32'(bus.sticky_v), 32'(STICKY_EN));
        check("sticky_set_wins_flags", 32'(dut_flags()), 32'b0010);
        bus.in_valid = 1'b0;
        step();
        check("sticky_clear", 32'(bus.sticky_v), 32'h0);
        bus.clr_sticky = 1'b0;
        drive(2'b11, 4'b1111, 8'h00, 1'b0, 1'b0);
        step();
        check("pass_no_sticky", 32'(bus.sticky_v), 32'h0);
        check("pass_zero_flags", 32'(dut_flags()), 32'b0011);

        // Reset asserted during a stall drops the pending result
        drive(2'b00, 4'b1111, 8'h55, 1'b0, 1'b0);
        step();
        check("pre_stall_y", 32'(bus.y), 32'h55);
        bus.out_ready = 1'b0;
        drive(2'b00, 4'b1111, 8'hAA, 1'b1, 1'b1);
        step();
        check("stall_y", 32'(bus.y), 32'h55);
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_y", 32'(bus.y), 32'h00);
        check("midrst_flags", 32'(dut_flags()), 32'b0001);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
